// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter granting one 8-way one-hot select; registered grant one edge after request.
// Optional macro ARB_TIMEOUT_EN adds a forced release after TIMEOUT_CYC held cycles.
module decoder_rr_arbiter #(
    parameter logic [2:0] RST_LAST    = 3'd7,
    parameter int         TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("decoder_rr_arbiter: TIMEOUT_CYC out of range 2..255");
    end

    logic [0:0] state_q, state_d;
    logic [2:0] last_q, last_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;

    logic [2:0] win_idx;
    logic [2:0] win_cand;
    logic       win_found;
    logic       release_c;
    logic       expire_c;

    // Rotating scan starting just after the last owner; offset 8 wraps back to last itself.
    always_comb begin
        win_idx   = 3'd0;
        win_cand  = 3'd0;
        win_found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            win_cand = last_q + 3'(i);
            if (!win_found && req[win_cand]) begin
                win_idx   = win_cand;
                win_found = 1'b1;
            end
        end
    end

    assign release_c = done | ~req[gnt_idx_q] | ~en;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // A coincident ordinary release takes precedence, so no timeout pulse then.
    assign expire_c = (cnt_q == 8'(TIMEOUT_CYC - 1)) & ~release_c;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = 8'd0;
        end else if (!release_c && !expire_c) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire_c = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && (req != 8'd0)) begin
                    state_d     = ST_GRANT;
                    gnt_idx_d   = win_idx;
                    gnt_d       = 8'd1 << win_idx;
                    gnt_valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_c || expire_c) begin
                    state_d     = ST_IDLE;
                    last_d      = gnt_idx_q;
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = expire_c;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 8'd0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= RST_LAST;
            gnt_q       <= 8'd0;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
